// File: rtl/ppu_deconverter.sv
// ppu_deconverter: rebuilds a linear 8bpp palette-index image from the SNES
// 8bpp bitplane tile image. Each strip is one 8-pixel row of one tile (8 plane
// bytes). Strips are processed in output raster order.
// Optional feature: define PPU_DECONV_CHECKSUM_EN for a 16-bit running sum of
// every written pixel. Without it, checksum is tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counters cleared, waiting for start_tick
// REQ   | read address driven, issue read when inReadOK is high
// WAIT  | read in flight, down-counter to latch inReadData into plane[k]
// XPOSE | transpose 8 plane bytes into 8 pixel indices
// WRITE | stream 8 pixels to linear RAM, then advance strip counters
// DONE  | one-cycle done_tick, back to IDLE
module ppu_deconverter #(
  parameter int TILES_X      = 25,
  parameter int TILES_Y      = 20,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        active,
  input  logic        start_tick,
  output logic        done_tick,
  output logic [14:0] inReadAddress,
  input  logic [7:0]  inReadData,
  input  logic        inReadOK,
  output logic [14:0] outWriteAddress,
  output logic        outWriteEN,
  output logic [7:0]  outWriteData,
  output logic [15:0] checksum
);

  localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam int WW  = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, XPOSE, WRITE, DONE} stateType;

  stateType       state;
  stateType       stateNext;
  logic [TXW-1:0] tileX;
  logic [2:0]     y;
  logic [TYW-1:0] tileRow;
  logic [2:0]     k;
  logic [2:0]     pixIdx;
  logic [WW-1:0]  waitCnt;
  logic [7:0]     plane [8];
  logic [7:0]     pix [8];
  logic           lastStrip;
  logic [14:0]    tileIndex;
  logic [14:0]    lineIdx;

  assign lastStrip = (tileX == TXW'(TILES_X - 1)) && (y == 3'd7) &&
                     (tileRow == TYW'(TILES_Y - 1));

  assign tileIndex     = 15'(tileRow) * 15'(TILES_X) + 15'(tileX);
  assign inReadAddress = (tileIndex << 6) | {9'd0, k[2:1], y, k[0]};

  assign lineIdx         = 15'(tileRow) * 15'd8 + {12'd0, y};
  assign outWriteAddress = lineIdx * 15'(TILES_X * 8) + 15'(tileX) * 15'd8 + {12'd0, pixIdx};
  assign outWriteData    = (state == WRITE) ? pix[pixIdx] : 8'd0;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode and control outputs
  always_comb begin
    stateNext  = state;
    active     = (state != IDLE);
    done_tick  = 1'b0;
    outWriteEN = 1'b0;
    case (state)
      IDLE:  if (start_tick) stateNext = REQ;
      REQ:   if (inReadOK) stateNext = WAIT;
      WAIT:  if (waitCnt == '0) stateNext = (k == 3'd7) ? XPOSE : REQ;
      XPOSE: stateNext = WRITE;
      WRITE: begin
        outWriteEN = 1'b1;
        if (pixIdx == 3'd7) stateNext = lastStrip ? DONE : REQ;
      end
      DONE: begin
        done_tick = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Strip counters, read-latency timer, plane capture and transpose
  always_ff @(posedge clock) begin
    if (reset) begin
      tileX   <= '0;
      y       <= '0;
      tileRow <= '0;
      k       <= '0;
      pixIdx  <= '0;
      waitCnt <= '0;
      for (int i = 0; i < 8; i++) begin
        plane[i] <= '0;
        pix[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          tileX   <= '0;
          y       <= '0;
          tileRow <= '0;
          k       <= '0;
          pixIdx  <= '0;
          waitCnt <= '0;
        end
        REQ: if (inReadOK) waitCnt <= WW'(READ_LATENCY - 1);
        WAIT: begin
          if (waitCnt == '0) begin
            plane[k] <= inReadData;
            if (k != 3'd7) k <= k + 3'd1;
          end else begin
            waitCnt <= waitCnt - WW'(1);
          end
        end
        XPOSE: begin
          // pixel 0 is the leftmost, i.e. bit 7 of every plane byte
          for (int i = 0; i < 8; i++)
            for (int b = 0; b < 8; b++)
              pix[i][b] <= plane[b][7-i];
        end
        WRITE: begin
          if (pixIdx == 3'd7) begin
            pixIdx <= '0;
            k      <= '0;
            if (tileX == TXW'(TILES_X - 1)) begin
              tileX <= '0;
              if (y == 3'd7) begin
                y <= '0;
                if (tileRow == TYW'(TILES_Y - 1)) tileRow <= '0;
                else tileRow <= tileRow + TYW'(1);
              end else begin
                y <= y + 3'd1;
              end
            end else begin
              tileX <= tileX + TXW'(1);
            end
          end else begin
            pixIdx <= pixIdx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PPU_DECONV_CHECKSUM_EN
  // Running sum of written pixels, cleared when a start is accepted
  always_ff @(posedge clock) begin
    if (reset)                            checksum <= '0;
    else if (state == IDLE && start_tick) checksum <= '0;
    else if (outWriteEN)                  checksum <= checksum + {8'd0, outWriteData};
  end
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_ppu_deconverter.sv
// Directed bench for ppu_deconverter with a 25x2 tile image so full frames
// stay short; the tile-26 strip and the linear address arithmetic still match
// the default 25-tile row width.
module tb_ppu_deconverter;

  localparam int TX   = 25;
  localparam int TY   = 2;
  localparam int RL   = 2;
  localparam int NPIX = TX * 8 * TY * 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        active;
  logic        startTick;
  logic        doneTick;
  logic [14:0] inReadAddress;
  logic [7:0]  inReadData;
  logic        inReadOK;
  logic [14:0] outWriteAddress;
  logic        outWriteEN;
  logic [7:0]  outWriteData;
  logic [15:0] checksum;

  always #5 clock = ~clock;

  ppu_deconverter #(.TILES_X(TX), .TILES_Y(TY), .READ_LATENCY(RL)) dut (
    .clock           (clock),
    .reset           (reset),
    .active          (active),
    .start_tick      (startTick),
    .done_tick       (doneTick),
    .inReadAddress   (inReadAddress),
    .inReadData      (inReadData),
    .inReadOK        (inReadOK),
    .outWriteAddress (outWriteAddress),
    .outWriteEN      (outWriteEN),
    .outWriteData    (outWriteData),
    .checksum        (checksum)
  );

  // framebuffer RAM model, two-cycle read latency
  logic [7:0] mem [32768];
  logic [7:0] rd1, rd2;
  always @(posedge clock) begin
    rd1 <= mem[inReadAddress];
    rd2 <= rd1;
  end
  assign inReadData = rd2;

  // output capture, owned only by this process
  logic [7:0]  outImg [NPIX];
  int          writeCount = 0;
  int          nonFFCount = 0;
  int          doneCount  = 0;
  int          sawCount   = 0;
  logic [14:0] lastAddr   = '0;
  always @(negedge clock) begin
    if (outWriteEN) begin
      writeCount++;
      lastAddr = outWriteAddress;
      if (outWriteData != 8'hFF) nonFFCount++;
      if (int'(outWriteAddress) < NPIX) outImg[outWriteAddress] = outWriteData;
    end
    if (doneTick) doneCount++;
    if (active && inReadAddress == 15'd1703) sawCount++;
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart;
    @(negedge clock);
    startTick = 1'b1;
    @(negedge clock);
    startTick = 1'b0;
  endtask

  task automatic waitWrite(input logic [14:0] addr, input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clock);
      if (outWriteEN && outWriteAddress == addr) found = 1'b1;
    end
  endtask

  task automatic waitDone(input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clock);
      if (doneTick) found = 1'b1;
    end
  endtask

  int          cyc, w0, n0, d0, s0, nonZero, stallBad;
  bit          got;
  logic [15:0] expSum;

  initial begin
    reset     = 1'b1;
    startTick = 1'b0;
    inReadOK  = 1'b1;
    for (int a = 0; a < 32768; a++) mem[a] = 8'hFF;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("rst_active",    active, 0);
    check("rst_done",      doneTick, 0);
    check("rst_wen",       outWriteEN, 0);
    check("rst_raddr",     inReadAddress, 0);
    check("rst_waddr",     outWriteAddress, 0);
    check("rst_wdata",     outWriteData, 0);
    check("rst_checksum",  checksum, 0);

    // full frame of 8'hFF, start pulses while busy and in DONE are ignored
    w0 = writeCount; n0 = nonFFCount; d0 = doneCount;
    startTick = 1'b1;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 20000) begin
      @(negedge clock);
      startTick = 1'b0;
      cyc++;
      if (doneTick) got = 1'b1;
      else if (cyc == 100) startTick = 1'b1;
    end
    check("frame_done_seen", got, 1);
    check("frame_cycles",    cyc, TX * TY * 8 * 33 + 2);
    check("done_active",     active, 1);
    startTick = 1'b1;
    @(negedge clock);
    startTick = 1'b0;
    check("idle_after_done", active, 0);
    repeat (40) @(negedge clock);
    check("still_idle",      active, 0);
    check("done_count",      doneCount - d0, 1);
    check("write_count",     writeCount - w0, NPIX);
    check("last_addr",       lastAddr, NPIX - 1);
    check("non_ff_writes",   nonFFCount - n0, 0);
`ifdef PPU_DECONV_CHECKSUM_EN
    expSum = 16'h7380;
`else
    expSum = 16'h0000;
`endif
    check("checksum",        checksum, expSum);

    // directed strips: tile 0 y 0, and tile 26 y 3; stall in REQ after strip 0
    for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
    for (int kk = 0; kk < 8; kk++) begin
      mem[(kk & 1) + (kk >> 1) * 16]                 = 8'h80 >> kk;
      mem[26 * 64 + (kk >> 1) * 16 + 3 * 2 + (kk & 1)] = 8'h01 << kk;
    end
    s0 = sawCount;
    pulseStart();
    waitWrite(15'd7, 200, got);
    check("strip0_end_seen", got, 1);
    inReadOK = 1'b0;
    stallBad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (outWriteEN || !active || inReadAddress != 15'd64) stallBad++;
    end
    check("stall_cycles_bad", stallBad, 0);
    check("stall_raddr",      inReadAddress, 64);
    inReadOK = 1'b1;
    waitDone(20000, got);
    check("frameB_done_seen", got, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("strip0_px%0d", i),    outImg[i],        8'h01 << i);
      check($sformatf("strip26y3_px%0d", i), outImg[2208 + i], 8'h80 >> i);
    end
    nonZero = 0;
    for (int i = 0; i < NPIX; i++) if (outImg[i] != 8'h00) nonZero++;
    check("nonzero_pixels", nonZero, 16);
    check("read_addr_1703_seen", (sawCount - s0) != 0, 1);

    // reset in the middle of a strip write
    pulseStart();
    waitWrite(15'd3, 200, got);
    check("mid_write_seen", got, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_wen",    outWriteEN, 0);
    check("rst_mid_active", active, 0);
    reset = 1'b0;
    pulseStart();
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      if (outWriteEN) got = 1'b1;
    end
    check("restart_write_seen", got, 1);
    check("restart_addr",       outWriteAddress, 0);
    check("restart_data",       outWriteData, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
